// File: rtl/imm_gen_pkg.sv
// Shared opcodes, immediate type codes and skid-buffer state codes for the immediate-generation stage.
package imm_gen_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OPCODE_W   = 7;
   localparam int unsigned IMM_TYPE_W = 3;

   // Base opcodes recognised by the stage
   localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OPC_FENCE  = 7'b0001111;
   localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

   // Immediate type codes as seen on imm_type_o
   localparam logic [IMM_TYPE_W-1:0] IMM_NONE  = 3'd0;
   localparam logic [IMM_TYPE_W-1:0] IMM_I     = 3'd1;
   localparam logic [IMM_TYPE_W-1:0] IMM_S     = 3'd2;
   localparam logic [IMM_TYPE_W-1:0] IMM_B     = 3'd3;
   localparam logic [IMM_TYPE_W-1:0] IMM_U     = 3'd4;
   localparam logic [IMM_TYPE_W-1:0] IMM_J     = 3'd5;
   localparam logic [IMM_TYPE_W-1:0] IMM_SHAMT = 3'd6;
   localparam logic [IMM_TYPE_W-1:0] IMM_ZIMM  = 3'd7;

   // Occupancy of the output/skid pair
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // OP-IMM funct3 values that carry a shift amount instead of an I immediate
   function automatic logic is_shift_imm(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Valid/ready buffer with an output register and an optional second (skid) entry.
module imm_skid_buf
   import imm_gen_pkg::*;
#(
   parameter int unsigned W       = 8,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   skid_state_e  state_q;
   logic [W-1:0] out_q;
   logic [W-1:0] skid_q;
   logic         out_valid_q;
   logic         in_ready_q;
   logic         in_xfer;
   logic         out_xfer;

   // With a skid entry the ready is registered; without it, ready follows the consumer
   assign in_ready_o  = SKID_EN ? in_ready_q : (!out_valid_q || out_ready_i);
   assign in_xfer     = in_valid_i && in_ready_o && !flush_i;
   assign out_xfer    = out_valid_q && out_ready_i;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_q;

   // Occupancy FSM; data registers only load on capture so held outputs stay stable
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush_i) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  out_q       <= in_data_i;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  out_q <= in_data_i;
               end else if (in_xfer && SKID_EN) begin
                  skid_q     <= in_data_i;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_TWO;
               end else if (out_xfer) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_xfer) begin
                  out_q      <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ST_ONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Fetch-to-decode stage: immediate extraction/extension, type classification,
// illegal-encoding flag and pc+imm precompute, registered through a skid buffer.
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [INSTR_W-1:0]    instr_i,
   input  logic [XLEN-1:0]       pc_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [INSTR_W-1:0]    instr_o,
   output logic [XLEN-1:0]       pc_o,
   output logic [XLEN-1:0]       imm_o,
   output logic [IMM_TYPE_W-1:0] imm_type_o,
   output logic [XLEN-1:0]       target_o,
   output logic                  is_ctrl_o,
   output logic                  illegal_o
);

   localparam int unsigned PAY_W = INSTR_W + 3 * XLEN + IMM_TYPE_W + 2;

   logic [OPCODE_W-1:0]   opcode;
   logic [2:0]            funct3;
   logic [31:0]           imm32;
   logic [IMM_TYPE_W-1:0] imm_type;
   logic                  illegal;
   logic [XLEN-1:0]       imm_ext;
   logic [XLEN-1:0]       target;
   logic                  is_ctrl;
   logic [PAY_W-1:0]      in_pay;
   logic [PAY_W-1:0]      out_pay;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];

   // Decode the immediate as a 32-bit value; zero-extended forms keep bit 31 clear
   always_comb begin
      imm32    = '0;
      imm_type = IMM_NONE;
      illegal  = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_JALR: begin
            imm_type = IMM_I;
            imm32    = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OPC_OP_IMM: begin
            if (is_shift_imm(funct3)) begin
               imm_type = IMM_SHAMT;
               imm32    = (XLEN == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
               illegal  = (XLEN == 32) && instr_i[25];
            end else begin
               imm_type = IMM_I;
               imm32    = {{20{instr_i[31]}}, instr_i[31:20]};
            end
         end
         OPC_STORE: begin
            imm_type = IMM_S;
            imm32    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         OPC_BRANCH: begin
            imm_type = IMM_B;
            imm32    = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            imm_type = IMM_U;
            imm32    = {instr_i[31:12], 12'b0};
         end
         OPC_JAL: begin
            imm_type = IMM_J;
            imm32    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
         end
         OPC_SYSTEM: begin
            if (funct3[2]) begin
               imm_type = IMM_ZIMM;
               imm32    = {27'b0, instr_i[19:15]};
            end
         end
         OPC_OP, OPC_FENCE: begin
            imm_type = IMM_NONE;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   // Extend to XLEN from bit 31; direct-target types get pc+imm, everything else pc+4
   assign imm_ext = XLEN'($signed(imm32));
   assign is_ctrl = (imm_type == IMM_B) || (imm_type == IMM_J);
   assign target  = pc_i + (is_ctrl ? imm_ext : XLEN'(4));

   assign in_pay = {instr_i, pc_i, imm_ext, imm_type, target, is_ctrl, illegal};

   imm_skid_buf #(
      .W       (PAY_W),
      .SKID_EN (SKID_EN)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_pay),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_pay)
   );

   assign {instr_o, pc_o, imm_o, imm_type_o, target_o, is_ctrl_o, illegal_o} = out_pay;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed and randomized checks of imm_gen_stage in three configurations.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [63:0] pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // XLEN32, skid enabled
   logic        r32_in_ready, r32_valid, r32_ctrl, r32_ill;
   logic [31:0] r32_instr, r32_pc, r32_imm, r32_tgt;
   logic [2:0]  r32_ty;
   // XLEN64, skid enabled
   logic        r64_in_ready, r64_valid, r64_ctrl, r64_ill;
   logic [31:0] r64_instr;
   logic [63:0] r64_pc, r64_imm, r64_tgt;
   logic [2:0]  r64_ty;
   // XLEN32, no skid
   logic        r0_in_ready, r0_valid, r0_ctrl, r0_ill;
   logic [31:0] r0_instr, r0_pc, r0_imm, r0_tgt;
   logic [2:0]  r0_ty;

   imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r32_in_ready),
      .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(r32_valid), .out_ready_i(out_ready),
      .instr_o(r32_instr), .pc_o(r32_pc), .imm_o(r32_imm), .imm_type_o(r32_ty),
      .target_o(r32_tgt), .is_ctrl_o(r32_ctrl), .illegal_o(r32_ill));

   imm_gen_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r64_in_ready),
      .instr_i(instr), .pc_i(pc), .out_valid_o(r64_valid), .out_ready_i(out_ready),
      .instr_o(r64_instr), .pc_o(r64_pc), .imm_o(r64_imm), .imm_type_o(r64_ty),
      .target_o(r64_tgt), .is_ctrl_o(r64_ctrl), .illegal_o(r64_ill));

   imm_gen_stage #(.XLEN(32), .SKID_EN(1'b0)) dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r0_in_ready),
      .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(r0_valid), .out_ready_i(out_ready),
      .instr_o(r0_instr), .pc_o(r0_pc), .imm_o(r0_imm), .imm_type_o(r0_ty),
      .target_o(r0_tgt), .is_ctrl_o(r0_ctrl), .illegal_o(r0_ill));

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  typ;
      logic [63:0] tgt;
      logic        ctrl;
      logic        ill;
   } exp_t;

   logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h00};

   logic [95:0] q1 [$];
   logic [95:0] q0 [$];

   // Reference: immediate rebuilt from bit fields with signed 64-bit arithmetic
   function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p, input int xl);
      exp_t        e;
      longint      si, u, imm;
      logic [63:0] mask;
      si  = longint'($signed(ins));
      u   = longint'({32'b0, ins});
      imm = 0;
      e   = '0;
      case (ins[6:0])
         7'h03, 7'h67: begin e.typ = 3'd1; imm = si >>> 20; end
         7'h13: begin
            if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
               e.typ = 3'd6;
               imm   = (u >> 20) & ((xl == 64) ? 63 : 31);
               e.ill = (xl == 32) && ins[25];
            end else begin
               e.typ = 3'd1;
               imm   = si >>> 20;
            end
         end
         7'h23: begin e.typ = 3'd2; imm = ((si >>> 25) << 5) | ((u >> 7) & 31); end
         7'h63: begin
            e.typ = 3'd3;
            imm = ((si >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                  | (((u >> 8) & 15) << 1);
         end
         7'h37, 7'h17: begin e.typ = 3'd4; imm = si & ~longint'(4095); end
         7'h6F: begin
            e.typ = 3'd5;
            imm = ((si >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                  | (((u >> 21) & 1023) << 1);
         end
         7'h73: if (ins[14]) begin e.typ = 3'd7; imm = (u >> 15) & 31; end
         7'h33, 7'h0F: e.typ = 3'd0;
         default: e.ill = 1'b1;
      endcase
      e.ctrl = (e.typ == 3'd3) || (e.typ == 3'd5);
      mask   = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      e.imm  = 64'(imm) & mask;
      e.tgt  = (e.ctrl ? p + e.imm : p + 64'd4) & mask;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // which: 0 = dut32, 1 = dut64, 2 = dut0
   task automatic check_out(input string tag, input int which, input logic [95:0] ent);
      logic [31:0] ins;
      logic [63:0] p, oi, op, oimm, otgt;
      logic [2:0]  oty;
      logic        oc, oil;
      int          xl;
      exp_t        e;
      ins = ent[95:64];
      p   = ent[63:0];
      xl  = (which == 1) ? 64 : 32;
      e   = model(ins, p, xl);
      case (which)
         0: begin
            oi = 64'(r32_instr); op = 64'(r32_pc); oimm = 64'(r32_imm); otgt = 64'(r32_tgt);
            oty = r32_ty; oc = r32_ctrl; oil = r32_ill;
         end
         1: begin
            oi = 64'(r64_instr); op = r64_pc; oimm = r64_imm; otgt = r64_tgt;
            oty = r64_ty; oc = r64_ctrl; oil = r64_ill;
         end
         default: begin
            oi = 64'(r0_instr); op = 64'(r0_pc); oimm = 64'(r0_imm); otgt = 64'(r0_tgt);
            oty = r0_ty; oc = r0_ctrl; oil = r0_ill;
         end
      endcase
      check({tag, ".instr"}, oi, 64'(ins));
      check({tag, ".pc"}, op, (xl == 32) ? (p & 64'hFFFF_FFFF) : p);
      check({tag, ".imm"}, oimm, e.imm);
      check({tag, ".type"}, 64'(oty), 64'(e.typ));
      check({tag, ".target"}, otgt, e.tgt);
      check({tag, ".ctrl"}, 64'(oc), 64'(e.ctrl));
      check({tag, ".illegal"}, 64'(oil), 64'(e.ill));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one entry with the consumer ready; returns with it on the outputs
   task automatic send(input logic [31:0] ins, input logic [63:0] p);
      in_valid  = 1'b1;
      instr     = ins;
      pc        = p;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      int          k;
      logic [31:0] r;
      k = $urandom_range(0, 11);
      r = $urandom;
      if (k != 11) r[6:0] = ops[k];
      return r;
   endfunction

   initial begin
      logic       in_x, out_x, rdy0;
      logic [95:0] ent;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; pc = '0;

      // Reset values
      #12;
      check("rst.valid32", 64'(r32_valid), 64'd0);
      check("rst.ready32", 64'(r32_in_ready), 64'd1);
      check("rst.imm32", 64'(r32_imm), 64'd0);
      check("rst.target32", 64'(r32_tgt), 64'd0);
      check("rst.valid64", 64'(r64_valid), 64'd0);
      check("rst.imm64", r64_imm, 64'd0);
      check("rst.valid0", 64'(r0_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // beq x0,x0,-8 at 0x100
      send(32'hFE000CE3, 64'h100);
      check("beq.valid", 64'(r32_valid), 64'd1);
      check("beq.imm", 64'(r32_imm), 64'hFFFF_FFF8);
      check("beq.type", 64'(r32_ty), 64'd3);
      check("beq.target", 64'(r32_tgt), 64'hF8);
      check("beq.ctrl", 64'(r32_ctrl), 64'd1);
      check_out("beq.m32", 0, {32'hFE000CE3, 64'h100});
      check_out("beq.m64", 1, {32'hFE000CE3, 64'h100});
      tick();

      // jal x1,+2048 at 0
      send(32'h001000EF, 64'h0);
      check("jal.imm", 64'(r32_imm), 64'h800);
      check("jal.type", 64'(r32_ty), 64'd5);
      check("jal.target", 64'(r32_tgt), 64'h800);
      check("jal.ctrl", 64'(r32_ctrl), 64'd1);
      tick();

      // lui with bit 31 set: XLEN64 sign-extends
      send(32'h800000B7, 64'h1000);
      check("lui.imm64", r64_imm, 64'hFFFF_FFFF_8000_0000);
      check("lui.type64", 64'(r64_ty), 64'd4);
      check("lui.target64", r64_tgt, 64'h1004);
      check("lui.ctrl64", 64'(r64_ctrl), 64'd0);
      check("lui.imm32", 64'(r32_imm), 64'h8000_0000);
      tick();

      // slli shamt 32: illegal on XLEN32, legal on XLEN64
      send(32'h02009093, 64'h0);
      check("slli.ill32", 64'(r32_ill), 64'd1);
      check("slli.type32", 64'(r32_ty), 64'd6);
      check("slli.ill64", 64'(r64_ill), 64'd0);
      check("slli.imm64", r64_imm, 64'd32);
      tick();

      // unknown opcode
      send(32'h0000007F, 64'h40);
      check("bad.ill", 64'(r32_ill), 64'd1);
      check("bad.type", 64'(r32_ty), 64'd0);
      check("bad.imm", 64'(r32_imm), 64'd0);
      check("bad.target", 64'(r32_tgt), 64'h44);
      tick();

      // Backpressure: three back-to-back, only two held
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'h00000013; pc = 64'h10;
      tick();
      instr = 32'h00100013; pc = 64'h14;
      tick();
      check("skid.ready_low", 64'(r32_in_ready), 64'd0);
      instr = 32'h00200013; pc = 64'h18;
      tick();
      in_valid = 1'b0;
      check("skid.valid", 64'(r32_valid), 64'd1);
      check("skid.first", 64'(r32_instr), 64'h00000013);
      check("skid.ready_still_low", 64'(r32_in_ready), 64'd0);
      check("noskid.first", 64'(r0_instr), 64'h00000013);
      check("noskid.ready", 64'(r0_in_ready), 64'd0);
      out_ready = 1'b1;
      tick();
      check("skid.second_valid", 64'(r32_valid), 64'd1);
      check("skid.second", 64'(r32_instr), 64'h00100013);
      check("skid.second_pc", 64'(r32_pc), 64'h14);
      check("noskid.drained", 64'(r0_valid), 64'd0);
      tick();
      check("skid.empty", 64'(r32_valid), 64'd0);
      check("skid.ready_back", 64'(r32_in_ready), 64'd1);

      // Flush with two held and an input presented
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'h00000013; pc = 64'h20;
      tick();
      instr = 32'h00100013; pc = 64'h24;
      tick();
      instr = 32'h00300013; pc = 64'h28; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush.valid32", 64'(r32_valid), 64'd0);
      check("flush.valid64", 64'(r64_valid), 64'd0);
      check("flush.valid0", 64'(r0_valid), 64'd0);
      check("flush.ready32", 64'(r32_in_ready), 64'd1);
      out_ready = 1'b1;
      tick();
      tick();
      check("flush.no_ghost", 64'(r32_valid), 64'd0);

      // Asynchronous reset between clock edges
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'h00400013; pc = 64'h30;
      tick();
      in_valid = 1'b0;
      check("arst.pre", 64'(r32_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst.valid32", 64'(r32_valid), 64'd0);
      check("arst.valid64", 64'(r64_valid), 64'd0);
      check("arst.ready32", 64'(r32_in_ready), 64'd1);
      check("arst.instr32", 64'(r32_instr), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Randomized stream against a queue model of the stage
      for (int n = 0; n < 800; n++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         instr     = rand_instr();
         pc        = {$urandom, $urandom} & ~64'h3;
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 49) == 0);
         #1;
         check("rnd.valid32", 64'(r32_valid), 64'(q1.size() > 0));
         check("rnd.valid64", 64'(r64_valid), 64'(q1.size() > 0));
         check("rnd.ready32", 64'(r32_in_ready), 64'(q1.size() < 2));
         check("rnd.ready64", 64'(r64_in_ready), 64'(q1.size() < 2));
         if (q1.size() > 0) begin
            ent = q1[0];
            check_out("rnd32", 0, ent);
            check_out("rnd64", 1, ent);
         end
         in_x  = in_valid && (q1.size() < 2) && !flush;
         out_x = (q1.size() > 0) && out_ready;
         if (flush) q1.delete();
         else begin
            if (out_x) void'(q1.pop_front());
            if (in_x) q1.push_back({instr, pc});
         end

         rdy0 = (q0.size() == 0) || out_ready;
         check("rnd.valid0", 64'(r0_valid), 64'(q0.size() > 0));
         check("rnd.ready0", 64'(r0_in_ready), 64'(rdy0));
         if (q0.size() > 0) begin
            ent = q0[0];
            check_out("rnd0", 2, ent);
         end
         in_x  = in_valid && rdy0 && !flush;
         out_x = (q0.size() > 0) && out_ready;
         if (flush) q0.delete();
         else begin
            if (out_x) void'(q0.pop_front());
            if (in_x) q0.push_back({instr, pc});
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
